dwa_scheduler_18: RTL and testbench

DWA_SCHEDULER_18 -- requirements
Module: dwa_scheduler_18

---
 rtl/dwa_scheduler_18.sv | 47 ++++
 tb/tb_dwa_scheduler_18.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dwa_scheduler_18.sv
// dwa_scheduler_18: 18-element unit selector, thermometer or data-weighted-averaging rotation
// Ports: clk, rst (sync, active-high); en/code_valid accept a sample; code_in = elements on (0..18);
//        mode 0 thermometer / 1 DWA; ptr_clr reloads pointer; sel_out (element k -> bit 17-k),
//        sel_valid pulse, ptr_out rotation pointer, ovr flags an out-of-range code. All outputs registered.
module dwa_scheduler_18 #(
  parameter int PTR_RST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        code_valid,
  input  logic [4:0]  code_in,
  input  logic        mode,
  input  logic        ptr_clr,
  output logic [17:0] sel_out,
  output logic        sel_valid,
  output logic [4:0]  ptr_out,
  output logic        ovr
);
  logic        acc, over;
  logic [4:0]  start, nxt;
  logic [5:0]  sum;
  logic [17:0] full, therm, rot;
  always_comb begin
    acc   = en & code_valid;
    over  = code_in > 5'd18;
    start = ptr_clr ? 5'(PTR_RST) : ptr_out;
    full  = '1;
    therm = ~(full >> code_in);
    rot   = 18'({therm, therm} >> start);
    sum   = {1'b0, start} + {1'b0, code_in};
    nxt   = 5'(sum >= 6'd18 ? sum - 6'd18 : sum);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_out   <= '0;
      sel_valid <= 1'b0;
      ovr       <= 1'b0;
      ptr_out   <= 5'(PTR_RST);
    end else begin
      sel_valid <= acc;
      ovr       <= acc & over;
      if (acc) sel_out <= over ? '0 : mode ? rot : therm;
      ptr_out <= (acc & mode & ~over) ? nxt : start;
    end
  end
endmodule

// File: tb/tb_dwa_scheduler_18.sv
// tb_dwa_scheduler_18: directed and randomized checks of dwa_scheduler_18 against a behavioural model
module tb_dwa_scheduler_18;
  logic        clk = 0, rst = 1, en = 0, code_valid = 0, mode = 0, ptr_clr = 0;
  logic [4:0]  code_in = 0;
  logic [17:0] sel_out;
  logic        sel_valid, ovr;
  logic [4:0]  ptr_out;
  int checks = 0, errors = 0;
  logic [17:0] m_sel;
  logic        m_valid, m_ovr;
  int          m_ptr;

  dwa_scheduler_18 dut (
    .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code_in(code_in),
    .mode(mode), .ptr_clr(ptr_clr), .sel_out(sel_out), .sel_valid(sel_valid),
    .ptr_out(ptr_out), .ovr(ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] elems_on(input int st, input int n);
    logic [17:0] s = '0;
    for (int i = 0; i < n; i++) s[17 - ((st + i) % 18)] = 1'b1;
    return s;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic v, input int c, input logic m, input logic p);
    int st;
    bit a;
    rst = r; en = e; code_valid = v; code_in = 5'(c); mode = m; ptr_clr = p;
    if (r) begin
      m_sel = '0; m_valid = 0; m_ovr = 0; m_ptr = 0;
    end else begin
      a = e && v;
      st = p ? 0 : m_ptr;
      m_valid = a;
      m_ovr = a && c > 18;
      if (a) m_sel = (c > 18) ? 18'b0 : elems_on(m ? st : 0, c);
      m_ptr = (a && m && c <= 18) ? (st + c) % 18 : st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 7, 1, 0);
    checks++;
    if ({sel_out, sel_valid, ovr, ptr_out} !== {18'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=0 v=0 ovr=0 ptr=0", sel_out, sel_valid, ovr, ptr_out);
    end
  endtask

  task automatic test_dwa_sequence;
    logic [17:0] es [4] = '{18'b111110000000000000, 18'b000001111100000000,
                            18'b000000000011111000, 18'b110000000000000111};
    int ep [4] = '{5, 10, 15, 2};
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 5, 1, 0);
      checks++;
      if ({sel_out, sel_valid, ovr, ptr_out} !== {es[i], 1'b1, 1'b0, 5'(ep[i]) }) begin
        errors++;
        $display("FAIL dwa_seq[%0d]: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=%b v=1 ovr=0 ptr=%0d",
                 i, sel_out, sel_valid, ovr, ptr_out, es[i], ep[i]);
      end
    end
  endtask

  task automatic test_thermometer;
    int codes [3] = '{0, 1, 18};
    logic [17:0] es [3] = '{18'b0, 18'b100000000000000000, 18'h3ffff};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, codes[i], 0, 0);
      checks++;
      if ({sel_out, sel_valid, ovr, ptr_out} !== {es[i], 1'b1, 1'b0, 5'd2}) begin
        errors++;
        $display("FAIL thermo[%0d]: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=%b v=1 ovr=0 ptr=2",
                 i, sel_out, sel_valid, ovr, ptr_out, es[i]);
      end
    end
  endtask

  task automatic test_full_and_overrange;
    cycle(0, 1, 1, 5, 1, 0);
    checks++;
    if (ptr_out !== 5'd7) begin errors++; $display("FAIL ptr_to_7: got %0d exp 7", ptr_out); end
    cycle(0, 1, 1, 18, 1, 0);
    checks++;
    if ({sel_out, sel_valid, ovr, ptr_out} !== {18'h3ffff, 1'b1, 1'b0, 5'd7}) begin
      errors++;
      $display("FAIL full18: got sel=%b v=%b ovr=%b ptr=%0d, exp all ones v=1 ovr=0 ptr=7", sel_out, sel_valid, ovr, ptr_out);
    end
    cycle(0, 1, 1, 23, 1, 0);
    checks++;
    if ({sel_out, sel_valid, ovr, ptr_out} !== {18'b0, 1'b1, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL ovr23: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=0 v=1 ovr=1 ptr=7", sel_out, sel_valid, ovr, ptr_out);
    end
    cycle(0, 0, 0, 3, 1, 0);
    checks++;
    if ({sel_out, sel_valid, ovr, ptr_out} !== {18'b0, 1'b0, 1'b0, 5'd7}) begin
      errors++;
      $display("FAIL ovr_pulse: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=0 v=0 ovr=0 ptr=7", sel_out, sel_valid, ovr, ptr_out);
    end
  endtask

  task automatic test_ptr_clr;
    cycle(0, 1, 1, 5, 1, 0);
    checks++;
    if (ptr_out !== 5'd12) begin errors++; $display("FAIL ptr_to_12: got %0d exp 12", ptr_out); end
    cycle(0, 1, 1, 3, 1, 1);
    checks++;
    if ({sel_out, sel_valid, ptr_out} !== {18'b111000000000000000, 1'b1, 5'd3}) begin
      errors++;
      $display("FAIL clr_with_sample: got sel=%b v=%b ptr=%0d, exp sel=111000000000000000 v=1 ptr=3", sel_out, sel_valid, ptr_out);
    end
    cycle(0, 0, 1, 9, 1, 1);
    checks++;
    if ({sel_out, sel_valid, ptr_out} !== {18'b111000000000000000, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL clr_no_en: got sel=%b v=%b ptr=%0d, exp sel held v=0 ptr=0", sel_out, sel_valid, ptr_out);
    end
  endtask

  task automatic test_hold_then_reset;
    cycle(0, 1, 1, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 11, 1, 0);
      checks++;
      if ({sel_out, sel_valid, ovr, ptr_out} !== {18'b111100000000000000, 1'b0, 1'b0, 5'd4}) begin
        errors++;
        $display("FAIL hold[%0d]: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=111100000000000000 v=0 ovr=0 ptr=4",
                 i, sel_out, sel_valid, ovr, ptr_out);
      end
    end
    cycle(1, 1, 1, 6, 1, 0);
    checks++;
    if ({sel_out, sel_valid, ovr, ptr_out} !== {18'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL rst_with_sample: got sel=%b v=%b ovr=%b ptr=%0d, exp all reset", sel_out, sel_valid, ovr, ptr_out);
    end
  endtask

  task automatic test_random;
    int c, prev;
    bit r, e, v, m, p;
    for (int i = 0; i < 10000; i++) begin
      prev = m_ptr;
      r = ($urandom_range(199) == 0);
      e = ($urandom_range(9) != 0);
      v = ($urandom_range(9) != 0);
      m = ($urandom_range(7) != 0);
      p = ($urandom_range(49) == 0);
      c = ($urandom_range(19) == 0) ? $urandom_range(31, 19) : $urandom_range(18);
      cycle(r, e, v, c, m, p);
      checks++;
      if ({sel_out, sel_valid, ovr, ptr_out} !== {m_sel, m_valid, m_ovr, 5'(m_ptr)}) begin
        errors++;
        $display("FAIL random[%0d]: got sel=%b v=%b ovr=%b ptr=%0d, exp sel=%b v=%b ovr=%b ptr=%0d",
                 i, sel_out, sel_valid, ovr, ptr_out, m_sel, m_valid, m_ovr, m_ptr);
      end
      checks++;
      if (ptr_out > 5'd17) begin errors++; $display("FAIL ptr_range[%0d]: got %0d exp <=17", i, ptr_out); end
      if (!r && e && v && m && c <= 18) begin
        checks++;
        if ($countones(sel_out) != c || sel_out !== elems_on(p ? 0 : prev, c)) begin
          errors++;
          $display("FAIL contiguity[%0d]: got sel=%b exp %0d elements from %0d", i, sel_out, c, p ? 0 : prev);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_dwa_sequence;
    test_thermometer;
    test_full_and_overrange;
    test_ptr_clr;
    test_hold_then_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
